// File: rtl/spi_intr_ctrl_pkg.sv
// Shared types and helpers for the SPI interrupt handshake controller.
package spi_intr_pkg;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PRE    = 5'b00010,
    ST_ASSERT = 5'b00100,
    ST_XFER   = 5'b01000,
    ST_POST   = 5'b10000
  } state_t;

  // Width of the shared delay counter: must hold the largest of the three delays
  function automatic int dcnt_w(input int pre_delay, input int pos_delay, input int timeout);
    int m;
    m = pre_delay;
    if (pos_delay > m) m = pos_delay;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_intr_ctrl_if.sv
// FIFO / host handshake signals of the SPI interrupt controller.
// master = FIFO + host side, slave = controller.
interface spi_intr_ctrl_if;
  logic package_ready;
  logic finish_trans;
  logic cs_n;
  logic intr_out;

  modport master (
    output package_ready,
    output cs_n,
    input  intr_out,
    input  finish_trans
  );

  modport slave (
    input  package_ready,
    input  cs_n,
    output intr_out,
    output finish_trans
  );
endinterface

// File: rtl/spi_intr_ctrl_cs_sync_edge.sv
// Synchroniser and edge detector for an asynchronous host-side strobe.
// Edge pulses are registered so downstream logic sees clean single-cycle flops.
module cs_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic fall,
  output logic rise
);
  logic meta;
  logic cs_s;
  logic cs_d;

  // Two-flop synchroniser, one delay flop, registered fall/rise pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      cs_s <= RESET_VAL;
      cs_d <= RESET_VAL;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= async_in;
      cs_s <= meta;
      cs_d <= cs_s;
      fall <= cs_d & ~cs_s;
      rise <= ~cs_d & cs_s;
    end
  end
endmodule

// File: rtl/spi_intr_ctrl.sv
// Handshake controller between the DAQ packet FIFO and the ESP32 SPI master.
// Counts FIFO packets against host drains and raises intr_out to request a transfer.
module spi_intr_ctrl
  import spi_intr_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int MAX_PENDING = 1023,
  parameter int PRE_DELAY   = 100,
  parameter int POS_DELAY   = 100,
  parameter int TIMEOUT     = 50000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  spi_intr_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             timeout_pulse,
  output logic             overflow,
  output logic             proto_err
);
  localparam int DCNT_W = dcnt_w(PRE_DELAY, POS_DELAY, TIMEOUT);
  localparam logic [DCNT_W-1:0] PRE_LAST = DCNT_W'(PRE_DELAY - 1);
  localparam logic [DCNT_W-1:0] POS_LAST = DCNT_W'(POS_DELAY - 1);
  localparam logic [DCNT_W-1:0] TO_LAST  = DCNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PEND_MAX = CNT_W'(MAX_PENDING);

  state_t            state;
  state_t            state_nxt;
  logic [DCNT_W-1:0] dcnt;
  logic              fall;
  logic              rise;
  logic              go_req;
  logic              xfer_done;
  logic              timeout_hit;

  cs_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .async_in (bus.cs_n),
    .fall     (fall),
    .rise     (rise)
  );

  assign go_req = enable && (pending != '0);

  // Next-state decode; fall beats the timeout in ASSERT
  always_comb begin
    state_nxt   = state;
    xfer_done   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:   if (go_req) state_nxt = ST_PRE;
      ST_PRE:    if (dcnt == PRE_LAST) state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (fall) begin
          state_nxt = ST_XFER;
        end else if (dcnt == TO_LAST) begin
          state_nxt   = ST_PRE;
          timeout_hit = 1'b1;
        end
      end
      ST_XFER: begin
        if (rise) begin
          state_nxt = ST_POST;
          xfer_done = 1'b1;
        end
      end
      ST_POST:   if (dcnt == POS_LAST) state_nxt = go_req ? ST_PRE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and delay counter, counter cleared on every state entry
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ST_IDLE || state == ST_XFER) dcnt <= '0;
      else dcnt <= dcnt + 1'b1;
    end
  end

  // Pending counter with saturation; simultaneous add and drain cancel out
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case ({bus.package_ready, xfer_done})
        2'b10: begin
          if (pending == PEND_MAX) overflow <= 1'b1;
          else pending <= pending + 1'b1;
        end
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Event pulses and sticky protocol error for host edges in the wrong state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.finish_trans <= 1'b0;
      timeout_pulse    <= 1'b0;
      proto_err        <= 1'b0;
    end else begin
      bus.finish_trans <= xfer_done;
      timeout_pulse    <= timeout_hit;
      if ((fall && state != ST_ASSERT) || (rise && state != ST_XFER)) proto_err <= 1'b1;
    end
  end

  assign bus.intr_out = (state == ST_ASSERT) || (state == ST_XFER);
  assign busy         = (state != ST_IDLE);

  // XFER is only reachable with packets outstanding, so a drain never underflows
  a_no_underflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    xfer_done |-> (pending != '0));

endmodule

// File: tb/tb_spi_intr_ctrl.sv
// Scoreboard bench for spi_intr_ctrl: the driver predicts event times from the
// handshake timing rules and queues them; a monitor pops and compares.
module tb_spi_intr_ctrl;
  localparam int CNT_W       = 10;
  localparam int MAX_PENDING = 3;
  localparam int PRE_DELAY   = 4;
  localparam int POS_DELAY   = 4;
  localparam int TIMEOUT     = 20;

  localparam int EV_RISE = 0;
  localparam int EV_FIN  = 1;
  localparam int EV_TO   = 2;

  typedef struct {
    int kind;
    int cyc;
    int pend;
  } ev_t;

  ev_t exp_q[$];

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             enable;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             timeout_pulse;
  logic             overflow;
  logic             proto_err;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   pend_m = 0;
  int   a_m = 0;
  logic intr_prev = 1'b0;

  spi_intr_ctrl_if bus();

  spi_intr_ctrl #(
    .CNT_W       (CNT_W),
    .MAX_PENDING (MAX_PENDING),
    .PRE_DELAY   (PRE_DELAY),
    .POS_DELAY   (POS_DELAY),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .enable        (enable),
    .bus           (bus),
    .pending       (pending),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .overflow      (overflow),
    .proto_err     (proto_err)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_RISE: return "intr_rise";
      EV_FIN:  return "finish_trans";
      default: return "timeout_pulse";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int p);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.pend = p;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected no event", kname(kind), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (kind != e.kind || cyc != e.cyc || int'(pending) != e.pend) begin
      failures++;
      $display("FAIL event_%s: got %s at cycle %0d pending %0d, expected %s at cycle %0d pending %0d",
               kname(e.kind), kname(kind), cyc, int'(pending), kname(e.kind), e.cyc, e.pend);
    end
  endtask

  // Monitor: compare every DUT event against the head of the expectation queue
  always @(negedge sys_clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_%s: got nothing by cycle %0d, expected at cycle %0d",
               kname(exp_q[0].kind), cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus.intr_out === 1'b1 && intr_prev !== 1'b1) observe(EV_RISE);
    if (bus.finish_trans === 1'b1) observe(EV_FIN);
    if (timeout_pulse === 1'b1) observe(EV_TO);
    intr_prev = bus.intr_out;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_ready(input int t);
    goto(t);
    bus.package_ready = 1'b1;
    goto(t + 1);
    bus.package_ready = 1'b0;
  endtask

  // One host transfer starting from the predicted intr_out rise a_m
  task automatic serve_one(input bit coincide);
    int f;
    int r;
    f = a_m + int'($urandom_range(0, 6));
    goto(f);
    bus.cs_n = 1'b0;
    r = f + int'($urandom_range(3, 12));
    goto(r);
    bus.cs_n = 1'b1;
    if (!coincide) pend_m--;
    push(EV_FIN, r + 4, pend_m);
    if (coincide) begin
      goto(r + 3);
      bus.package_ready = 1'b1;
      goto(r + 4);
      bus.package_ready = 1'b0;
    end
    if (pend_m > 0) begin
      a_m = r + 4 + POS_DELAY + PRE_DELAY;
      push(EV_RISE, a_m, pend_m);
    end else begin
      goto(r + 3 + POS_DELAY);
      chk("busy_in_post_wait", int'(busy), 1);
      goto(r + 4 + POS_DELAY);
      chk("busy_back_to_idle", int'(busy), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by cycle %0d, expected end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int n;
    int a;
    int f;
    int p;

    sys_rst           = 1'b1;
    enable            = 1'b1;
    bus.cs_n          = 1'b1;
    bus.package_ready = 1'b0;
    goto(4);
    sys_rst = 1'b0;
    goto(5);
    chk("reset_intr_out", int'(bus.intr_out), 0);
    chk("reset_finish_trans", int'(bus.finish_trans), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_timeout_pulse", int'(timeout_pulse), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_proto_err", int'(proto_err), 0);

    // Single packet with fixed timeline
    pend_m = 1;
    push(EV_RISE, 10 + 2 + PRE_DELAY, 1);
    pulse_ready(10);
    chk("pending_after_ready", int'(pending), 1);
    goto(20);
    bus.cs_n = 1'b0;
    goto(40);
    bus.cs_n = 1'b1;
    pend_m = 0;
    push(EV_FIN, 44, 0);
    goto(47);
    chk("single_busy_post", int'(busy), 1);
    goto(48);
    chk("single_idle_48", int'(busy), 0);

    // Back-to-back packets, then drain them all
    t = cyc + int'($urandom_range(2, 6));
    n = int'($urandom_range(2, 3));
    goto(t);
    bus.package_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      goto(t + k + 1);
      if (k == n - 1) bus.package_ready = 1'b0;
      chk("pending_count_up", int'(pending), k + 1);
    end
    pend_m = n;
    a_m    = t + 2 + PRE_DELAY;
    push(EV_RISE, a_m, pend_m);
    while (pend_m > 0) serve_one(1'b0);

    // Host timeout and retry
    t = cyc + 3;
    pend_m = 1;
    a = t + 2 + PRE_DELAY;
    push(EV_RISE, a, 1);
    push(EV_TO, a + TIMEOUT, 1);
    a_m = a + TIMEOUT + PRE_DELAY;
    push(EV_RISE, a_m, 1);
    pulse_ready(t);
    goto(a + TIMEOUT - 1);
    chk("intr_high_before_timeout", int'(bus.intr_out), 1);
    goto(a + TIMEOUT);
    chk("intr_low_after_timeout", int'(bus.intr_out), 0);
    goto(a_m - 1);
    chk("intr_low_end_of_retry", int'(bus.intr_out), 0);
    chk("pending_kept_on_timeout", int'(pending), 1);
    serve_one(1'b0);

    // Saturation with requests gated off, then a stray cs_n pulse in IDLE
    goto(cyc + 1);
    enable = 1'b0;
    t = cyc + 2;
    chk("overflow_clear_before", int'(overflow), 0);
    goto(t);
    bus.package_ready = 1'b1;
    goto(t + 3);
    chk("pending_at_max", int'(pending), MAX_PENDING);
    chk("overflow_not_yet", int'(overflow), 0);
    goto(t + 5);
    bus.package_ready = 1'b0;
    pend_m = MAX_PENDING;
    goto(t + 6);
    chk("pending_saturated", int'(pending), MAX_PENDING);
    chk("overflow_sticky", int'(overflow), 1);
    chk("enable_low_stays_idle", int'(busy), 0);
    chk("proto_err_clear_before", int'(proto_err), 0);
    p = cyc + 2;
    goto(p);
    bus.cs_n = 1'b0;
    goto(p + 3);
    bus.cs_n = 1'b1;
    goto(p + 12);
    chk("proto_err_idle_cs", int'(proto_err), 1);
    chk("pending_after_stray_cs", int'(pending), MAX_PENDING);
    chk("idle_after_stray_cs", int'(busy), 0);

    // Re-enable; first drain coincides with a new packet
    t = cyc + 1;
    goto(t);
    enable = 1'b1;
    a_m = t + 1 + PRE_DELAY;
    push(EV_RISE, a_m, pend_m);
    serve_one(1'b1);
    while (pend_m > 0) serve_one(1'b0);

    // Reset while the host is mid-transfer
    t = cyc + 3;
    pend_m = 1;
    a = t + 2 + PRE_DELAY;
    push(EV_RISE, a, 1);
    pulse_ready(t);
    f = a + 2;
    goto(f);
    bus.cs_n = 1'b0;
    goto(f + 6);
    sys_rst = 1'b1;
    goto(f + 7);
    sys_rst = 1'b0;
    pend_m = 0;
    chk("rst_xfer_intr_out", int'(bus.intr_out), 0);
    chk("rst_xfer_busy", int'(busy), 0);
    chk("rst_xfer_pending", int'(pending), 0);
    chk("rst_xfer_finish", int'(bus.finish_trans), 0);
    chk("rst_xfer_timeout", int'(timeout_pulse), 0);
    chk("rst_xfer_overflow", int'(overflow), 0);
    chk("rst_xfer_proto_err", int'(proto_err), 0);
    goto(f + 10);
    bus.cs_n = 1'b1;
    goto(f + 20);
    chk("proto_err_after_reset_rise", int'(proto_err), 1);
    chk("pending_after_reset_rise", int'(pending), 0);
    chk("idle_after_reset_rise", int'(busy), 0);

    goto(cyc + 5);
    chk("expectations_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_intr_ctrl.md
# spi_intr_ctrl

Single-clock handshake controller between the DAQ packet FIFO and the ESP32 SPI master. It counts packets ready in the FIFO against packets the host has drained, and raises `intr_out` to request a transfer. Programmable pre- and post-transfer guard delays and a host-response timeout with retry are parameters, not fixed constants. It sits between the FIFO's `package_ready` pulse, the host's `cs_n`, and the FIFO's `finish_trans` input.

## Interface
- `CNT_W`, 10: width of the pending-packet counter.
- `MAX_PENDING`, 1023: saturation value of the pending counter, ≤ 2^CNT_W−1.
- `PRE_DELAY`, 100: cycles in PRE_WAIT before `intr_out` rises, ≥1.
- `POS_DELAY`, 100: cycles in POST_WAIT after the `cs_n` rise, ≥1.
- `TIMEOUT`, 50000: cycles in ASSERT without a `cs_n` fall before retry, ≥1.

Ports:
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  allows new requests; an in-flight transfer always completes.
- `package_ready`  in  1  one-cycle pulse, one more packet is in the FIFO.
- `cs_n`  in  1  SPI chip select from host, asynchronous.
- `intr_out`  out  1  transfer request to host.
- `finish_trans`  out  1  one-cycle pulse, a packet has been drained.
- `pending`  out  CNT_W  packets awaiting transfer.
- `busy`  out  1  state ≠ IDLE.
- `timeout_pulse`  out  1  one-cycle pulse on host timeout.
- `overflow`  out  1  sticky: a `package_ready` was lost at saturation.
- `proto_err`  out  1  sticky: a `cs_n` edge arrived in an illegal state.

## Operation
- `cs_n` passes through a 2-flop synchroniser (`cs_s`) plus one delay flop (`cs_d`). `fall = cs_d & ~cs_s`, `rise = ~cs_d & cs_s`. The synchroniser resets to 1 (deasserted).
- States, one-hot: IDLE, PRE_WAIT, ASSERT, XFER, POST_WAIT. A single delay counter `dcnt` is cleared on every state entry.
- IDLE → PRE_WAIT when `enable && pending != 0`.
- PRE_WAIT → ASSERT when `dcnt == PRE_DELAY-1`.
- ASSERT:
  - On `fall` → XFER.
  - Else, when `dcnt == TIMEOUT-1` → PRE_WAIT and pulse `timeout_pulse`.
  - `fall` wins if both occur in the same cycle.
- XFER → POST_WAIT on `rise`. Pulse `finish_trans` and decrement `pending`.
- POST_WAIT, when `dcnt == POS_DELAY-1`: → PRE_WAIT if `enable && pending != 0`, else → IDLE.
- `intr_out` is 1 exactly in ASSERT and XFER. It is driven from the state flops, with no combinational path from inputs.
- Pending counter:
  - +1 on `package_ready`; −1 on transfer completion.
  - Both in one cycle: unchanged.
  - Increment at MAX_PENDING: stays, sets `overflow`.
  - Decrement at 0 cannot occur because XFER is entered only with `pending > 0`; the RTL asserts this.
- Protocol errors: `fall` outside ASSERT, or `rise` outside XFER, is ignored and sets `proto_err`.
- `enable` low in PRE_WAIT or ASSERT: finish the current request. Gating applies only at the IDLE and POST_WAIT decision points.

## Timing
- Reset values: state IDLE, `dcnt` 0, `pending` 0. All outputs 0.
- Reset mid-transfer drops `intr_out` the next cycle and discards the pending count.
- `package_ready` at cycle t: `pending` updates at t+1.
- From idle with pending 0: `package_ready` at t gives PRE_WAIT at t+2 and `intr_out` high at t+2+PRE_DELAY.
- `cs_n` pin edge to `fall`/`rise` detection: 3 cycles.
- `intr_out` falls and `finish_trans` pulses 1 cycle after `rise` detection, together with the `pending` decrement.
- Next `intr_out` rise after a `cs_n` rise (pending > 0): POS_DELAY + PRE_DELAY + 4 cycles.
- Timeout retry: `intr_out` is low for exactly PRE_DELAY cycles.

## Structure
- Package `spi_intr_pkg`:
  - State enum/one-hot constants.
  - Function `dcnt_w = $clog2(max(PRE_DELAY, POS_DELAY, TIMEOUT) + 1)`.
- Sub-module `cs_sync_edge`: synchroniser, delay flop and `fall`/`rise` outputs. It is reused by the other host-facing blocks.
- The top holds the FSM, `dcnt`, the pending counter and the sticky flags.

## Test plan
- Single packet, PRE_DELAY=4, POS_DELAY=4: `package_ready` at cycle 10 → `intr_out` rises at cycle 16. `cs_n` low at 20, high at 40 → `finish_trans` at cycle 44, `pending` back to 0, IDLE by cycle 48.
- Three back-to-back `package_ready` pulses → `pending` counts 1, 2, 3. Three cs cycles give three `intr_out` pulses, each separated by ≥ POS_DELAY+PRE_DELAY low cycles; final `pending` is 0.
- TIMEOUT=20 with no `cs_n` activity → `timeout_pulse` after 20 ASSERT cycles, `intr_out` low for PRE_DELAY cycles, then reasserts; `pending` is unchanged.
- MAX_PENDING=3 with 5 `package_ready` pulses → `pending`=3 and `overflow`=1. A `package_ready` in the same cycle as `finish_trans` leaves `pending` unchanged.
- A `cs_n` pulse while IDLE → `proto_err`=1, no `finish_trans`, `pending` unchanged.
- `sys_rst` asserted while in XFER → next cycle all outputs 0 and state IDLE. A subsequent `cs_n` rise is flagged as `proto_err`.
